if_fetch_queue: RTL

// - Instruction-fetch stage ahead of the IF/ID pipeline register. It owns the PC and issues

---
 rtl/if_fetch_queue.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction-fetch stage. Owns the PC, issues word reads to
// imem, tags in-order responses with their PC and buffers them in a prefetch
// FIFO whose head is presented to ID through registered outputs.
// Optional build macro IFQ_PERF_EN adds perf_fetched / perf_starve counters.
module if_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
`ifdef IFQ_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_starve
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUT + 1);
  localparam int unsigned TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  // occupancy + outstanding never exceeds 2*DEPTH
  localparam int unsigned SW = CW + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ifq_entry_t;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t            state;
  logic [31:0]       pc;

  ifq_entry_t        fifo_mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [CW-1:0]     occ;

  logic [31:0]       tag_mem [MAX_OUT];
  logic [TW-1:0]     tag_rd;
  logic [TW-1:0]     tag_wr;
  logic [OW-1:0]     outstanding;
  logic [OW-1:0]     drop_cnt;

  logic              issue_c;
  logic              ret_c;
  logic              drop_c;
  logic              push_c;
  logic              pop_c;
  logic [CW-1:0]     occ_left_c;
  ifq_entry_t        push_ent_c;
  ifq_entry_t        head_nxt_c;
  logic              head_vld_nxt_c;

  // Circular increment for the tag queue (MAX_OUT need not be a power of 2)
  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUT - 1)) ? '0 : p + TW'(1);
  endfunction

  // Per-cycle qualifiers: issue, response return, drop, FIFO push and pop
  always_comb begin
    ret_c   = imem_rvalid && (outstanding != '0);
    drop_c  = ret_c && (drop_cnt != '0);
    push_c  = ret_c && (drop_cnt == '0) && !redirect_valid;
    pop_c   = id_valid && id_ready && !redirect_valid;
    issue_c = (state == FETCH) && !redirect_valid &&
              (outstanding < OW'(MAX_OUT)) &&
              ((SW'(occ) + SW'(outstanding)) < SW'(DEPTH));
  end

  assign imem_req  = issue_c;
  assign imem_addr = pc;

  // Next FIFO head, so the ID-facing registers never depend on id_ready combinationally
  always_comb begin
    occ_left_c     = occ - CW'(pop_c);
    push_ent_c     = '{instr: imem_rdata, pc: tag_mem[tag_rd]};
    head_nxt_c     = '0;
    head_vld_nxt_c = 1'b0;
    if (!redirect_valid) begin
      if (occ_left_c != '0) begin
        head_vld_nxt_c = 1'b1;
        head_nxt_c     = fifo_mem[rd_ptr + AW'(pop_c)];
      end else if (push_c) begin
        head_vld_nxt_c = 1'b1;
        head_nxt_c     = push_ent_c;
      end
    end
  end

  // Fetch control FSM: BOOT for one cycle, FLUSH for the cycle after any redirect
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= BOOT;
    end else begin
      unique case (state)
        BOOT:    state <= redirect_valid ? FLUSH : FETCH;
        FETCH:   state <= redirect_valid ? FLUSH : FETCH;
        FLUSH:   state <= redirect_valid ? FLUSH : FETCH;
        default: state <= BOOT;
      endcase
    end
  end

  // Program counter: redirect wins, otherwise advance on each issued request
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc & ~32'h3;
    end else if (issue_c) begin
      pc <= pc + 32'd4;
    end
  end

  // In-flight bookkeeping: every response retires one request, stale ones are counted out
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_rd      <= '0;
      tag_wr      <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      if (issue_c) begin
        tag_wr <= tag_inc(tag_wr);
      end
      if (ret_c) begin
        tag_rd <= tag_inc(tag_rd);
      end
      outstanding <= outstanding + OW'(issue_c) - OW'(ret_c);
      if (redirect_valid) begin
        drop_cnt <= outstanding - OW'(ret_c);
      end else if (drop_c) begin
        drop_cnt <= drop_cnt - OW'(1);
      end
    end
  end

  // PC tag storage for requests in flight
  always_ff @(posedge clock) begin
    if (issue_c) begin
      tag_mem[tag_wr] <= pc;
    end
  end

  // Prefetch FIFO pointers and occupancy; a redirect empties it
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      occ <= occ + CW'(push_c) - CW'(pop_c);
    end
  end

  // Prefetch FIFO storage
  always_ff @(posedge clock) begin
    if (push_c) begin
      fifo_mem[wr_ptr] <= push_ent_c;
    end
  end

  // Registered head presented to ID; zeros whenever nothing valid is held
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc    <= '0;
    end else begin
      id_valid <= head_vld_nxt_c;
      id_instr <= head_nxt_c.instr;
      id_pc    <= head_nxt_c.pc;
    end
  end

`ifdef IFQ_PERF_EN
  // Saturating counters: instructions handed to ID, and FETCH cycles with nothing to hand over
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched <= '0;
      perf_starve  <= '0;
    end else begin
      if (pop_c && (perf_fetched != 32'hFFFF_FFFF)) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if ((state == FETCH) && !id_valid && (perf_starve != 32'hFFFF_FFFF)) begin
        perf_starve <= perf_starve + 32'd1;
      end
    end
  end
`else
  // Performance counters not built
`endif

endmodule
